// File: rtl/spi_reg_responder_if.sv
// Serial pins of the 3/4-wire config bus between a master (mkFTop side) and a register responder.
interface spi_reg_responder_if;
  logic spi_sclk;
  logic spi_sen;
  logic spi_sdata;
  logic spi_sdout;
  logic spi_sdout_oe;

  modport master (output spi_sclk, spi_sen, spi_sdata, input spi_sdout, spi_sdout_oe);
  modport slave  (input spi_sclk, spi_sen, spi_sdata, output spi_sdout, spi_sdout_oe);
endinterface

// File: rtl/spi_reg_responder.sv
// SPI-slave NREG x 8 register file; 16-bit frames {RnW, addr[6:0], data[7:0]} on oversampled pins.
// Latency: pin edges act SYNC_STAGES+1 clocks later; commits land the clock after the 16th edge.
// Backpressure: none; a local write colliding with an SPI commit is dropped and flagged.
module spi_reg_responder #(
  parameter int NREG        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  spi_reg_responder_if.slave   spi,
  output logic [NREG*8-1:0]    regs_flat,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic [7:0]           wr_data,
  input  logic                 lcl_we,
  input  logic [6:0]           lcl_addr,
  input  logic [7:0]           lcl_data,
  output logic                 lcl_conflict,
  output logic                 abort,
  output logic                 addr_err
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [7:0] NREG_W = 8'(NREG);

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [7:0]             regs [NREG];
  logic [SYNC_STAGES-1:0] sclk_sync, sen_sync, sdata_sync;
  logic                   sclk_s, sen_s, sdata_s, sclk_d, sen_d;
  logic                   sclk_rise, sclk_fall, sen_rise, sen_fall;
  logic [2:0]             state;
  logic [3:0]             bit_cnt;
  logic [6:0]             rx;
  logic                   rnw, addr_ok;
  logic [6:0]             addr;
  logic [7:0]             tx;
  logic                   active, cmd_done, data_done, spi_commit;
  logic [6:0]             frame_addr;
  logic [7:0]             frame_data;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NREG_W;
  endfunction

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign sen_s      = sen_sync[SYNC_STAGES-1];
  assign sdata_s    = sdata_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign sen_rise   = sen_s & ~sen_d;
  assign sen_fall   = ~sen_s & sen_d;

  assign active     = (state == ST_CMD) || (state == ST_DATA);
  assign frame_addr = {rx[5:0], sdata_s};
  assign frame_data = {rx, sdata_s};
  assign cmd_done   = (state == ST_CMD)  && sclk_rise && !sen_rise && (bit_cnt == 4'd7);
  assign data_done  = (state == ST_DATA) && sclk_rise && !sen_rise && (bit_cnt == 4'd15);
  assign spi_commit = data_done && !rnw && addr_ok;

  // sen resets to 0 so a frame already in progress at reset release is never joined mid-way
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sclk_sync  <= '0;
      sen_sync   <= '0;
      sdata_sync <= '0;
      sclk_d     <= 1'b0;
      sen_d      <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
      sen_sync   <= {sen_sync[SYNC_STAGES-2:0], spi.spi_sen};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], spi.spi_sdata};
      sclk_d     <= sclk_s;
      sen_d      <= sen_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_WAIT;
      bit_cnt <= '0;
      rx      <= '0;
      rnw     <= 1'b0;
      addr    <= '0;
      addr_ok <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: if (sen_s) state <= ST_IDLE;
        ST_IDLE: begin
          if (sen_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        ST_CMD, ST_DATA: begin
          if (sen_rise) begin
            state <= ST_IDLE;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            rx      <= {rx[5:0], sdata_s};
            if (cmd_done) begin
              state   <= ST_DATA;
              rnw     <= rx[6];
              addr    <= frame_addr;
              addr_ok <= in_range(frame_addr);
            end
            if (data_done) state <= ST_DONE;
          end
        end
        ST_DONE: if (sen_rise) state <= ST_IDLE;
        default: state <= ST_WAIT;
      endcase
    end
  end

  // The first falling edge after the command byte is skipped so bit 7 is still on the
  // pin when the master samples at the 9th rising edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx               <= 8'h00;
      spi.spi_sdout    <= 1'b0;
      spi.spi_sdout_oe <= 1'b0;
      abort            <= 1'b0;
      addr_err         <= 1'b0;
      wr_strobe        <= 1'b0;
      lcl_conflict     <= 1'b0;
    end else begin
      abort        <= sen_rise && active;
      addr_err     <= cmd_done && !in_range(frame_addr);
      wr_strobe    <= spi_commit;
      lcl_conflict <= spi_commit && lcl_we;
      if (cmd_done)
        tx <= (rx[6] && in_range(frame_addr)) ? regs[frame_addr[AW-1:0]] : 8'h00;
      else if ((state == ST_DATA) && sclk_fall && !sen_rise && (bit_cnt >= 4'd9))
        tx <= {tx[6:0], 1'b0};
      spi.spi_sdout_oe <= (state == ST_DATA) && rnw;
      spi.spi_sdout    <= (state == ST_DATA) && rnw && tx[7];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (spi_commit) begin
      regs[addr[AW-1:0]] <= frame_data;
      wr_addr            <= addr;
      wr_data            <= frame_data;
    end else if (lcl_we && in_range(lcl_addr)) begin
      regs[lcl_addr[AW-1:0]] <= lcl_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Drives the responder as an SPI master at CLK/16 and checks against a byte-array register model.
module tb_spi_reg_responder;
  localparam int NREG        = 16;
  localparam int SYNC_STAGES = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NREG*8-1:0] regs_flat;
  logic              wr_strobe, lcl_conflict, abort, addr_err;
  logic [6:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              lcl_we;
  logic [6:0]        lcl_addr;
  logic [7:0]        lcl_data;

  spi_reg_responder_if spi_if();

  spi_reg_responder #(.NREG(NREG), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RST_N(RST_N), .spi(spi_if),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_data(lcl_data),
    .lcl_conflict(lcl_conflict), .abort(abort), .addr_err(addr_err)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0, n_abort = 0, n_addr_err = 0, n_conflict = 0;
  logic [7:0] model [NREG];

  int lw_bit = -1;
  int rst_bit = -1;
  logic [6:0] lw_addr;
  logic [7:0] lw_data;

  always @(negedge CLK) begin
    if (wr_strobe === 1'b1)    n_strobe++;
    if (abort === 1'b1)        n_abort++;
    if (addr_err === 1'b1)     n_addr_err++;
    if (lcl_conflict === 1'b1) n_conflict++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NREG*8-1:0] exp_flat();
    logic [NREG*8-1:0] v = '0;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = model[i];
    return v;
  endfunction

  task automatic lcl_write(input int a, input logic [7:0] d);
    @(negedge CLK);
    lcl_we = 1'b1; lcl_addr = 7'(a); lcl_data = d;
    @(negedge CLK);
    lcl_we = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // Master frame: data set while sclk low, sclk held 8 CLKs per phase, sdout/oe sampled at each rise.
  task automatic spi_frame(input logic [15:0] frame, input int nbits,
                           output logic [7:0] rd, output logic [19:0] oe_seen);
    rd = 8'h00;
    oe_seen = '0;
    @(negedge CLK);
    spi_if.spi_sen = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      spi_if.spi_sdata = (i < 16) ? frame[15-i] : 1'($urandom_range(0, 1));
      repeat (8) @(negedge CLK);
      spi_if.spi_sclk = 1'b1;
      oe_seen[i] = spi_if.spi_sdout_oe;
      if (i >= 8 && i < 16) rd = {rd[6:0], spi_if.spi_sdout};
      if (lw_bit == i) begin
        repeat (SYNC_STAGES) @(negedge CLK);
        lcl_we = 1'b1; lcl_addr = lw_addr; lcl_data = lw_data;
        @(negedge CLK);
        lcl_we = 1'b0;
        repeat (8 - SYNC_STAGES - 1) @(negedge CLK);
      end else if (rst_bit == i) begin
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
      end else begin
        repeat (8) @(negedge CLK);
      end
      spi_if.spi_sclk = 1'b0;
    end
    repeat (8) @(negedge CLK);
    spi_if.spi_sen = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    spi_if.spi_sen = 1'b1; spi_if.spi_sclk = 1'b0; spi_if.spi_sdata = 1'b0;
    lcl_we = 1'b0; lcl_addr = '0; lcl_data = '0;
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (regs_flat !== '0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs_flat); end
    n_tests++;
    if ({spi_if.spi_sdout, spi_if.spi_sdout_oe} !== 2'b00) begin
      n_fail++; $display("FAIL reset_sdout: got %b want 00", {spi_if.spi_sdout, spi_if.spi_sdout_oe});
    end
    n_tests++;
    if ({wr_addr, wr_data} !== 15'h0) begin
      n_fail++; $display("FAIL reset_wr_hold: got %h/%h want 0/0", wr_addr, wr_data);
    end
    n_tests++;
    if ({wr_strobe, abort, addr_err, lcl_conflict} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {wr_strobe, abort, addr_err, lcl_conflict});
    end
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);
  endtask

  task automatic test_write();
    logic [7:0] rd; logic [19:0] oe; int s0;
    s0 = n_strobe;
    spi_frame(16'h03A5, 16, rd, oe);
    model[3] = 8'hA5;
    n_tests++;
    if (regs_flat !== exp_flat()) begin n_fail++; $display("FAIL write_regs: got %h want %h", regs_flat, exp_flat()); end
    n_tests++;
    if (n_strobe - s0 != 1) begin n_fail++; $display("FAIL write_strobe: got %0d pulses want 1", n_strobe - s0); end
    n_tests++;
    if (wr_addr !== 7'd3 || wr_data !== 8'hA5) begin
      n_fail++; $display("FAIL write_hold: got %h/%h want 03/a5", wr_addr, wr_data);
    end
    n_tests++;
    if (oe !== 20'h0) begin n_fail++; $display("FAIL write_oe: got %h want 0", oe); end
  endtask

  task automatic test_read();
    logic [7:0] rd; logic [19:0] oe;
    spi_frame(16'h8300 | 16'($urandom_range(0, 255)), 16, rd, oe);
    n_tests++;
    if (rd !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h want a5", rd); end
    n_tests++;
    if (oe !== 20'h0FF00) begin n_fail++; $display("FAIL read_oe_window: got %h want 0ff00", oe); end
    n_tests++;
    if ({spi_if.spi_sdout, spi_if.spi_sdout_oe} !== 2'b00) begin
      n_fail++; $display("FAIL read_after: got %b want 00", {spi_if.spi_sdout, spi_if.spi_sdout_oe});
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic [19:0] oe; int s0, a0;
    s0 = n_strobe; a0 = n_abort;
    spi_frame(16'h055A, 12, rd, oe);
    n_tests++;
    if (n_abort - a0 != 1) begin n_fail++; $display("FAIL abort_pulse: got %0d want 1", n_abort - a0); end
    n_tests++;
    if (n_strobe - s0 != 0) begin n_fail++; $display("FAIL abort_strobe: got %0d want 0", n_strobe - s0); end
    n_tests++;
    if (regs_flat !== exp_flat()) begin n_fail++; $display("FAIL abort_regs: got %h want %h", regs_flat, exp_flat()); end
  endtask

  task automatic test_addr_err();
    logic [7:0] rd; logic [19:0] oe; int s0, e0;
    s0 = n_strobe; e0 = n_addr_err;
    spi_frame(16'h20FF, 16, rd, oe);
    n_tests++;
    if (n_addr_err - e0 != 1) begin n_fail++; $display("FAIL adrerr_wr_pulse: got %0d want 1", n_addr_err - e0); end
    n_tests++;
    if (n_strobe - s0 != 0 || regs_flat !== exp_flat()) begin
      n_fail++; $display("FAIL adrerr_wr_discard: strobes %0d regs %h want 0 / %h", n_strobe - s0, regs_flat, exp_flat());
    end
    e0 = n_addr_err;
    spi_frame(16'hA0C3, 16, rd, oe);
    n_tests++;
    if (rd !== 8'h00 || n_addr_err - e0 != 1) begin
      n_fail++; $display("FAIL adrerr_read: got data %h pulses %0d want 00 / 1", rd, n_addr_err - e0);
    end
  endtask

  task automatic test_conflict();
    logic [7:0] rd; logic [19:0] oe; int s0, c0;
    s0 = n_strobe; c0 = n_conflict;
    lw_bit = 15; lw_addr = 7'd3; lw_data = 8'h11;
    spi_frame(16'h0377, 16, rd, oe);
    lw_bit = -1;
    model[3] = 8'h77;
    n_tests++;
    if (regs_flat !== exp_flat()) begin n_fail++; $display("FAIL conflict_spi_wins: got %h want %h", regs_flat, exp_flat()); end
    n_tests++;
    if (n_conflict - c0 != 1 || n_strobe - s0 != 1) begin
      n_fail++; $display("FAIL conflict_pulses: conflict %0d strobe %0d want 1/1", n_conflict - c0, n_strobe - s0);
    end
    c0 = n_conflict;
    lcl_write(3, 8'h11);
    model[3] = 8'h11;
    n_tests++;
    if (regs_flat !== exp_flat() || n_conflict != c0) begin
      n_fail++; $display("FAIL conflict_next_lcl: got %h conflicts %0d want %h / 0", regs_flat, n_conflict - c0, exp_flat());
    end
  endtask

  task automatic test_local_and_snapshot();
    logic [7:0] rd; logic [19:0] oe;
    lcl_write(9, 8'h3C);
    model[9] = 8'h3C;
    lcl_write(NREG + 5, 8'hFF);
    n_tests++;
    if (regs_flat !== exp_flat()) begin n_fail++; $display("FAIL local_write: got %h want %h", regs_flat, exp_flat()); end
    lw_bit = 11; lw_addr = 7'd9; lw_data = 8'hE7;
    spi_frame(16'h8900, 16, rd, oe);
    lw_bit = -1;
    n_tests++;
    if (rd !== 8'h3C) begin n_fail++; $display("FAIL snapshot_read: got %h want 3c", rd); end
    model[9] = 8'hE7;
    n_tests++;
    if (regs_flat !== exp_flat()) begin n_fail++; $display("FAIL snapshot_regs: got %h want %h", regs_flat, exp_flat()); end
  endtask

  task automatic test_done_ignored();
    logic [7:0] rd; logic [19:0] oe; int s0;
    s0 = n_strobe;
    spi_frame(16'h0642, 20, rd, oe);
    model[6] = 8'h42;
    n_tests++;
    if (regs_flat !== exp_flat() || n_strobe - s0 != 1) begin
      n_fail++; $display("FAIL long_frame: got %h strobes %0d want %h / 1", regs_flat, n_strobe - s0, exp_flat());
    end
    n_tests++;
    if (oe !== 20'h0 || spi_if.spi_sdout !== 1'b0) begin
      n_fail++; $display("FAIL long_frame_out: oe %h sdout %b want 0/0", oe, spi_if.spi_sdout);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rd; logic [19:0] oe; int s0, a0;
    s0 = n_strobe; a0 = n_abort;
    rst_bit = 4;
    spi_frame(16'h0799, 16, rd, oe);
    rst_bit = -1;
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    n_tests++;
    if (regs_flat !== '0 || n_strobe != s0) begin
      n_fail++; $display("FAIL midreset_no_commit: got %h strobes %0d want 0 / 0", regs_flat, n_strobe - s0);
    end
    n_tests++;
    if (n_abort != a0) begin n_fail++; $display("FAIL midreset_abort: got %0d want 0", n_abort - a0); end
    spi_frame(16'h0799, 16, rd, oe);
    model[7] = 8'h99;
    n_tests++;
    if (regs_flat !== exp_flat() || n_strobe - s0 != 1) begin
      n_fail++; $display("FAIL midreset_next_frame: got %h strobes %0d want %h / 1", regs_flat, n_strobe - s0, exp_flat());
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, d, expd; logic [19:0] oe; int a, kind, s0, e0;
    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(NREG, 127) : $urandom_range(0, NREG - 1);
      d = 8'($urandom_range(0, 255));
      s0 = n_strobe; e0 = n_addr_err;
      if (kind == 0) begin
        spi_frame({1'b0, 7'(a), d}, 16, rd, oe);
        if (a < NREG) model[a] = d;
        n_tests++;
        if (n_strobe - s0 != ((a < NREG) ? 1 : 0) || n_addr_err - e0 != ((a < NREG) ? 0 : 1)) begin
          n_fail++; $display("FAIL rand_write_pulses it%0d: strobe %0d adrerr %0d addr %0d", it, n_strobe - s0, n_addr_err - e0, a);
        end
        if (a < NREG) begin
          n_tests++;
          if (wr_addr !== 7'(a) || wr_data !== d) begin
            n_fail++; $display("FAIL rand_write_hold it%0d: got %h/%h want %h/%h", it, wr_addr, wr_data, 7'(a), d);
          end
        end
      end else if (kind == 1) begin
        expd = (a < NREG) ? model[a] : 8'h00;
        spi_frame({1'b1, 7'(a), d}, 16, rd, oe);
        n_tests++;
        if (rd !== expd) begin n_fail++; $display("FAIL rand_read it%0d: addr %0d got %h want %h", it, a, rd, expd); end
        if (a < NREG) begin
          n_tests++;
          if (oe !== 20'h0FF00) begin n_fail++; $display("FAIL rand_read_oe it%0d: got %h want 0ff00", it, oe); end
        end
      end else begin
        lcl_write(a, d);
        if (a < NREG) model[a] = d;
      end
      n_tests++;
      if (regs_flat !== exp_flat()) begin n_fail++; $display("FAIL rand_regs it%0d: got %h want %h", it, regs_flat, exp_flat()); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_addr_err();
    test_conflict();
    test_local_and_snapshot();
    test_done_ignored();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
